// File: rtl/ecc_pkg.sv
// Purpose: shared encodings for the ECC ladder scheduler (command ops, FSM states, default key size).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ecc_pkg;

    // Default scalar width; matches a 256-bit curve.
    localparam int ECC_KEY_BITS = 256;

    // Encoding of cmd_op towards the ladder-step unit.
    typedef enum logic [1:0] {
        ECC_OP_INIT   = 2'd0,
        ECC_OP_LADDER = 2'd1,
        ECC_OP_FINAL  = 2'd2
    } ecc_op_e;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ecc_state_e;

endpackage

// File: rtl/ecc_scalar_shreg.sv
// Purpose: holds the latched scalar and the previous ladder bit; presents scalar[idx].
// Latency: load/update take effect on the next clk edge; cur_bit is combinational from idx.
// Backpressure: none; the scheduler decides when to load and when to update prev.
//
// Ports: load/scalar_in capture a new scalar and clear prev; upd_prev copies
// the current bit into prev; idx selects the bit presented on cur_bit.
module ecc_scalar_shreg
    import ecc_pkg::*;
#(
    parameter int KEY_BITS = ECC_KEY_BITS,
    parameter int IDX_W    = $clog2(KEY_BITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [KEY_BITS-1:0] scalar_in,
    input  logic [IDX_W-1:0]    idx,
    input  logic                upd_prev,
    output logic                cur_bit,
    output logic                prev
);

    logic [KEY_BITS-1:0] scalar_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scalar_q <= '0;
            prev     <= 1'b0;
        end else if (load) begin
            scalar_q <= scalar_in;
            prev     <= 1'b0;
        end else if (upd_prev) begin
            prev     <= scalar_q[idx];
        end
    end

    assign cur_bit = scalar_q[idx];

endmodule

// File: rtl/ecc_ladder_sched.sv
// Purpose: sequences one Montgomery ladder (INIT, KEY_BITS x LADDER MSB->LSB, FINAL) on an external step unit.
// Latency: 2*(KEY_BITS+2)+1 cycles acceptance->res_valid with a zero-wait step unit; constant for every scalar.
// Backpressure: req_ready only in IDLE; cmd held stable until cmd_ready; result held until res_ready.
//
// Ports: req_* scalar request in; cmd_* command out to the step unit;
// rsp_valid completion pulse from the step unit; res_* result handshake out.
// Option: define ECC_ZERO_SCALAR_CHECK_EN to reject an all-zero scalar with res_err=1.
module ecc_ladder_sched
    import ecc_pkg::*;
#(
    parameter int KEY_BITS = ECC_KEY_BITS,
    parameter int IDX_W    = $clog2(KEY_BITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_BITS-1:0] req_scalar,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [1:0]          cmd_op,
    output logic                cmd_swap,
    input  logic                rsp_valid,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_err
);

    ecc_state_e       state_q, state_d;
    ecc_op_e          phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             load, upd_prev, cur_bit, prev;
    logic             accept, zero_rej;

    assign accept = req_valid && (state_q == ST_IDLE);

    ecc_scalar_shreg #(
        .KEY_BITS (KEY_BITS),
        .IDX_W    (IDX_W)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .scalar_in (req_scalar),
        .idx       (idx_q),
        .upd_prev  (upd_prev),
        .cur_bit   (cur_bit),
        .prev      (prev)
    );

`ifdef ECC_ZERO_SCALAR_CHECK_EN
    logic err_q;

    assign zero_rej = accept && (req_scalar == '0);

    // Error flag is captured per request and only visible while in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= zero_rej;
        end
    end

    assign res_err = (state_q == ST_DONE) && err_q;
`else
    assign zero_rej = 1'b0;
    assign res_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= ECC_OP_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic. Every bit takes the same path (no early exit) so the
    // command count and timing do not depend on the scalar value.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        load     = 1'b0;
        upd_prev = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    idx_d   = IDX_W'(KEY_BITS - 1);
                    phase_d = ECC_OP_INIT;
                    state_d = zero_rej ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    state_d = ST_ISSUE;
                    case (phase_q)
                        ECC_OP_INIT: phase_d = ECC_OP_LADDER;
                        ECC_OP_LADDER: begin
                            upd_prev = 1'b1;
                            if (idx_q == '0) begin
                                phase_d = ECC_OP_FINAL;
                            end else begin
                                idx_d = idx_q - 1'b1;
                            end
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. In ISSUE, phase/idx/prev/scalar are frozen, so op and swap
    // stay stable for as long as the step unit stalls.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        cmd_valid = 1'b0;
        cmd_op    = ECC_OP_INIT;
        cmd_swap  = 1'b0;
        res_valid = (state_q == ST_DONE);
        if (state_q == ST_ISSUE) begin
            cmd_valid = 1'b1;
            cmd_op    = phase_q;
            case (phase_q)
                ECC_OP_LADDER: cmd_swap = cur_bit ^ prev;
                ECC_OP_FINAL:  cmd_swap = prev;
                default:       cmd_swap = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_ladder_sched.sv
// Purpose: directed self-checking bench for ecc_ladder_sched with KEY_BITS=8 and a behavioural step unit.
// Latency: compares acceptance->res_valid against 2*(K+2)+1 plus any injected cmd_ready stall.
// Backpressure: exercises cmd_ready stalls, res_ready hold-off, busy-time requests and stray rsp_valid.
module tb_ecc_ladder_sched;

    localparam int K = 8;
    localparam logic [1:0] OP_INIT   = 2'd0;
    localparam logic [1:0] OP_LADDER = 2'd1;
    localparam logic [1:0] OP_FINAL  = 2'd2;

    typedef struct packed {
        logic [1:0] op;
        logic       swap;
    } cmd_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [K-1:0] req_scalar = '0;
    logic         cmd_valid;
    logic         cmd_ready = 1'b0;
    logic [1:0]   cmd_op;
    logic         cmd_swap;
    logic         rsp_valid = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         res_err;

    int   checks = 0;
    int   errors = 0;
    cmd_t exp_q[$];

    always #5 clk = ~clk;

    ecc_ladder_sched #(.KEY_BITS(K)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_scalar (req_scalar),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_swap   (cmd_swap),
        .rsp_valid  (rsp_valid),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_err    (res_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, " cmd_op"},    32'(cmd_op),    32'd0);
        chk({tag, " cmd_swap"},  32'(cmd_swap),  32'd0);
        chk({tag, " res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, " res_err"},   32'(res_err),   32'd0);
    endtask

    // One request through a behavioural step unit. hold = cycles cmd_ready is
    // kept low on each command; rsp_valid pulses the cycle after acceptance.
    // abort != 0 returns in the WAIT cycle after that many commands.
    task automatic run_req(input logic [K-1:0] sc, input int hold, input int res_hold,
                           input bit busy_req, input bit stray, input int abort,
                           input string tag);
        logic prv;
        bit   exp_err, acc_last;
        int   exp_n, exp_lat, ncmd, held, done_cyc, first_cyc;
        cmd_t got, first_seen, want;

        exp_q.delete();
        exp_err = 1'b0;
`ifdef ECC_ZERO_SCALAR_CHECK_EN
        if (sc == '0) exp_err = 1'b1;
`endif
        if (!exp_err) begin
            exp_q.push_back(cmd_t'{op: OP_INIT, swap: 1'b0});
            prv = 1'b0;
            for (int i = K - 1; i >= 0; i--) begin
                exp_q.push_back(cmd_t'{op: OP_LADDER, swap: sc[i] ^ prv});
                prv = sc[i];
            end
            exp_q.push_back(cmd_t'{op: OP_FINAL, swap: prv});
        end
        exp_n   = exp_q.size();
        exp_lat = exp_err ? 1 : (2 + hold) * exp_n + 1;

        @(negedge clk);
        chk({tag, " req_ready before request"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_scalar = sc;
        @(posedge clk);
        #1;
        req_valid  = busy_req;
        req_scalar = busy_req ? ~sc : sc;

        ncmd = 0; held = 0; acc_last = 1'b0; done_cyc = 0; first_cyc = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (abort != 0 && acc_last && ncmd == abort) begin
                rsp_valid = 1'b0;
                cmd_ready = 1'b0;
                req_valid = 1'b0;
                return;
            end
            rsp_valid = acc_last;
            acc_last  = 1'b0;
            cmd_ready = 1'b0;
            if (res_valid) begin
                done_cyc = c;
                break;
            end
            if (busy_req) chk({tag, " req_ready while busy"}, 32'(req_ready), 32'd0);
            if (cmd_valid) begin
                got = cmd_t'{op: cmd_op, swap: cmd_swap};
                if (first_cyc == 0) first_cyc = c;
                if (held == 0) first_seen = got;
                else chk({tag, " cmd stable while stalled"}, 32'(got), 32'(first_seen));
                if (stray && held == 1) rsp_valid = 1'b1;
                if (held >= hold) begin
                    cmd_ready = 1'b1;
                    acc_last  = 1'b1;
                    held      = 0;
                    ncmd++;
                    if (exp_q.size() != 0) want = exp_q.pop_front();
                    else want = cmd_t'(3'b111);
                    chk($sformatf("%s cmd#%0d", tag, ncmd), 32'(got), 32'(want));
                end else begin
                    held++;
                end
            end
        end
        rsp_valid = 1'b0;
        req_valid = 1'b0;

        chk({tag, " res latency"},       32'(done_cyc),     32'(exp_lat));
        chk({tag, " cmd count"},         32'(ncmd),         32'(exp_n));
        chk({tag, " first cmd cycle"},   32'(first_cyc),    exp_err ? 32'd0 : 32'd1);
        chk({tag, " res_err"},           32'(res_err),      32'(exp_err));
        chk({tag, " expected left"},     32'(exp_q.size()), 32'd0);

        for (int i = 0; i < res_hold; i++) begin
            @(negedge clk);
            chk({tag, " res_valid held"}, 32'(res_valid), 32'd1);
            chk({tag, " req_ready held"}, 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, " req_ready after result"}, 32'(req_ready), 32'd1);
        chk({tag, " res_valid after result"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Stray completion in IDLE must not start anything.
        @(negedge clk) rsp_valid = 1'b1;
        @(negedge clk) rsp_valid = 1'b0;
        chk("idle stray req_ready", 32'(req_ready), 32'd1);
        chk("idle stray cmd_valid", 32'(cmd_valid), 32'd0);

        run_req(8'hA5, 0, 0, 1'b0, 1'b0, 0, "a5");
        run_req(8'h01, 0, 0, 1'b0, 1'b0, 0, "01");
        run_req(8'hFF, 0, 0, 1'b0, 1'b0, 0, "ff");
        run_req(8'hA5, 5, 0, 1'b0, 1'b1, 0, "a5 stall");
        run_req(8'h00, 0, 0, 1'b0, 1'b0, 0, "zero");
        run_req(8'hC3, 0, 10, 1'b1, 1'b0, 0, "c3 busy");

        // Abort in the WAIT following the 4th LADDER (5th command overall).
        run_req(8'hA5, 0, 0, 1'b0, 1'b0, 5, "abort");
        rst_n = 1'b0;
        #1 chk_reset_outputs("mid reset");
        repeat (2) begin
            @(negedge clk);
            chk("mid reset no cmd", 32'(cmd_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk) rsp_valid = 1'b1;
        @(negedge clk) rsp_valid = 1'b0;
        chk("late rsp req_ready", 32'(req_ready), 32'd1);
        chk("late rsp cmd_valid", 32'(cmd_valid), 32'd0);
        chk("late rsp res_valid", 32'(res_valid), 32'd0);
        run_req(8'h3C, 0, 0, 1'b0, 1'b0, 0, "3c after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
